// File: rtl/tx_channel.sv
// tx_channel: HDLC transmit serialiser with flags, zero-bit insertion and abort sequence.
module tx_channel #(
  parameter logic [7:0] FLAG_PATTERN  = 8'h7E,
  parameter logic [7:0] ABORT_PATTERN = 8'hFE,
  parameter int         STUFF_LIMIT   = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_ValidFrame,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_AbortFrame,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);
  typedef enum logic [2:0] {IDLE, OPEN, DATA, CLOSE, ABORT} state_t;
  state_t state, nxt;
  logic [2:0] cnt, ones;
  logic [7:0] sh;
  logic pend, act, abt, stuff, last, tx_d, done_d, aborted_d;
  assign act   = state inside {OPEN, DATA, CLOSE};
  assign abt   = Tx_Enable && act && (Tx_AbortFrame || pend);
  // A pending stuffed 0 is honoured in CLOSE too, so it precedes the closing flag.
  assign stuff = (state inside {DATA, CLOSE}) && ones == 3'(STUFF_LIMIT);
  assign last  = cnt == 3'd7;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (abt) nxt = ABORT;
    else if (Tx_Enable)
      case (state)
        IDLE:    nxt = Tx_ValidFrame ? OPEN : IDLE;
        OPEN:    nxt = last ? (Tx_ValidFrame ? DATA : CLOSE) : OPEN;
        DATA:    nxt = (!stuff && last && !Tx_ValidFrame) ? CLOSE : DATA;
        CLOSE:   nxt = (!stuff && last) ? IDLE : CLOSE;
        ABORT:   nxt = last ? IDLE : ABORT;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    Tx_RdBuff = Tx_Enable && !abt && Tx_ValidFrame && last &&
                (state == OPEN || (state == DATA && !stuff));
    tx_d      = abt              ? ABORT_PATTERN[0] :
                state == OPEN    ? FLAG_PATTERN[cnt] :
                state == DATA    ? (!stuff && sh[0]) :
                state == CLOSE   ? (!stuff && FLAG_PATTERN[cnt]) :
                state == ABORT   ? ABORT_PATTERN[cnt] : 1'b1;
    done_d    = Tx_Enable && !abt && state == CLOSE && !stuff && last;
    aborted_d = Tx_Enable && state == ABORT && last;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      Tx              <= 1'b1;
      Tx_Done         <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      cnt             <= '0;
      ones            <= '0;
      sh              <= '0;
      pend            <= 1'b0;
    end else begin
      Tx_Done         <= done_d;
      Tx_AbortedTrans <= aborted_d;
      pend            <= Tx_Enable ? 1'b0 : pend || (Tx_AbortFrame && act);
      if (Tx_Enable) begin
        Tx   <= tx_d;
        cnt  <= abt ? 3'd1 : state == IDLE ? 3'd0 : stuff ? cnt : cnt + 3'd1;
        ones <= (state == DATA && !abt && !stuff && sh[0]) ? ones + 3'd1 : 3'd0;
        sh   <= Tx_RdBuff ? Tx_Data : (state == DATA && !abt && !stuff) ? sh >> 1 : sh;
      end
    end
endmodule

// File: tb/tb_tx_channel.sv
// tb_tx_channel: randomized and directed frames checked slot by slot against a bitstream model.
module tb_tx_channel;
  logic Clk = 0, Rst = 1, Tx_Enable = 0, Tx_ValidFrame = 0, Tx_AbortFrame = 0;
  logic [7:0] Tx_Data = 0;
  logic Tx_RdBuff, Tx, Tx_Done, Tx_AbortedTrans;
  int checks = 0, fails = 0;
  logic [7:0] frame[$];
  typedef struct packed {logic b, rd, dn, ab, v; logic [7:0] d;} slot_t;
  slot_t sl[$];
  logic prev_tx = 1;
  localparam logic [7:0] FLAG = 8'h7E, ABRT = 8'hFE;

  tx_channel dut (.Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_ValidFrame(Tx_ValidFrame),
                  .Tx_Data(Tx_Data), .Tx_AbortFrame(Tx_AbortFrame), .Tx_RdBuff(Tx_RdBuff),
                  .Tx(Tx), .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans));

  always #5 Clk = ~Clk;

  function automatic slot_t mk(logic b, logic rd, logic dn, logic ab, logic v, logic [7:0] d);
    slot_t s;
    s.b = b; s.rd = rd; s.dn = dn; s.ab = ab; s.v = v; s.d = d;
    return s;
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line slots: idle slot that starts the frame, opening flag, stuffed data,
  // closing flag; an abort at slot k replaces everything from k with the abort sequence.
  task automatic build(input int abort_at);
    int n, ones;
    logic bt, rd;
    n = frame.size();
    ones = 0;
    sl.delete();
    sl.push_back(mk(1, 0, 0, 0, 1, 8'h00));
    for (int i = 0; i < 8; i++)
      sl.push_back(mk(FLAG[i], i == 7 && n > 0, 0, 0, n > 0, n > 0 ? frame[0] : 8'h00));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        if (ones == 5) begin
          sl.push_back(mk(0, 0, 0, 0, 1, 8'h00));
          ones = 0;
        end
        bt = frame[i][j];
        ones = bt ? ones + 1 : 0;
        rd = j == 7 && i + 1 < n;
        sl.push_back(mk(bt, rd, 0, 0, i + 1 < n, rd ? frame[i + 1] : 8'($urandom)));
      end
    if (ones == 5) sl.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 8; i++) sl.push_back(mk(FLAG[i], 0, i == 7, 0, 0, 8'h00));
    if (abort_at > 0) begin
      while (sl.size() > abort_at) void'(sl.pop_back());
      for (int i = 0; i < 8; i++) sl.push_back(mk(ABRT[i], 0, 0, i == 7, 0, 8'h00));
    end
    for (int i = 0; i < 3; i++) sl.push_back(mk(1, 0, 0, 0, 0, 8'h00));
  endtask

  // gap_mode: 0 never disabled, 1 disabled cycle before every slot, 2 random.
  // pend_gap moves the abort request into a disabled cycle before slot abort_at.
  task automatic run(input int abort_at, input int gap_mode, input bit pend_gap, input int stop_at);
    bit gap;
    build(abort_at);
    for (int i = 0; i < sl.size(); i++) begin
      if (stop_at >= 0 && i == stop_at) return;
      gap = gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1) || (pend_gap && i == abort_at);
      if (gap) begin
        @(negedge Clk);
        Tx_Enable = 0; Tx_ValidFrame = sl[i].v; Tx_Data = 8'($urandom);
        Tx_AbortFrame = pend_gap && i == abort_at;
        #1 chk("rdbuff_disabled", Tx_RdBuff, 0);
        @(posedge Clk); #1;
        chk("tx_hold", Tx, prev_tx);
        chk("done_disabled", Tx_Done, 0);
        chk("aborted_disabled", Tx_AbortedTrans, 0);
      end
      @(negedge Clk);
      Tx_Enable = 1; Tx_ValidFrame = sl[i].v; Tx_Data = sl[i].d;
      Tx_AbortFrame = !pend_gap && i == abort_at;
      #1 chk("rdbuff", Tx_RdBuff, sl[i].rd);
      @(posedge Clk); #1;
      chk("tx_bit", Tx, sl[i].b);
      chk("done", Tx_Done, sl[i].dn);
      chk("aborted", Tx_AbortedTrans, sl[i].ab);
      prev_tx = sl[i].b;
    end
    @(negedge Clk);
    Tx_AbortFrame = 0; Tx_ValidFrame = 0;
  endtask

  initial begin
    int len, ab;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_tx", Tx, 1);
    chk("reset_rdbuff", Tx_RdBuff, 0);
    chk("reset_done", Tx_Done, 0);
    chk("reset_aborted", Tx_AbortedTrans, 0);
    @(negedge Clk) Rst = 0;
    frame = '{8'h00};            run(-1, 0, 0, -1);
    frame = '{8'hFF};            run(-1, 0, 0, -1);
    frame = '{8'hF8, 8'h03};     run(-1, 0, 0, -1);
    frame = {};                  run(-1, 0, 0, -1);
    frame = '{8'hFF, 8'hFF, 8'hFF}; run(-1, 0, 0, -1);
    frame = '{8'h11, 8'h22, 8'h33}; run(21, 0, 0, -1);
    frame = '{8'h7E};            run(-1, 1, 0, -1);
    frame = '{8'h7E, 8'h7E};     run(14, 1, 1, -1);
    frame = '{8'h55};            run(24, 0, 0, -1);
    frame = '{8'hA5};            run(3, 0, 0, -1);
    // Abort requests while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Tx_Enable = 1; Tx_ValidFrame = 0; Tx_AbortFrame = 1;
      @(posedge Clk); #1;
      chk("idle_abort_tx", Tx, 1);
      chk("idle_abort_pulse", Tx_AbortedTrans, 0);
    end
    @(negedge Clk) Tx_AbortFrame = 0;
    // Asynchronous reset in the middle of the data phase.
    frame = '{8'hFF, 8'h0F};     run(-1, 0, 0, 13);
    @(negedge Clk);
    Tx_ValidFrame = 0;
    #3 Rst = 1;
    #1;
    chk("async_rst_tx", Tx, 1);
    chk("async_rst_rdbuff", Tx_RdBuff, 0);
    chk("async_rst_done", Tx_Done, 0);
    chk("async_rst_aborted", Tx_AbortedTrans, 0);
    @(negedge Clk) Rst = 0;
    prev_tx = 1;
    frame = '{8'h3C};            run(-1, 0, 0, -1);
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(0, 4);
      frame = {};
      for (int i = 0; i < len; i++)
        frame.push_back($urandom_range(0, 1) == 1 ? 8'hFF ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom));
      build(-1);
      ab = $urandom_range(0, 3) == 0 ? $urandom_range(1, sl.size() - 4) : -1;
      run(ab, 2, ab > 0 && $urandom_range(0, 1) == 1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
